sb_ram40_4k: RTL and testbench

Single-clock 4 Kbit block RAM: a 256×16 physical array with independent write and read ports, each configurable as 256×16, 512×8, 1024×4 or 2048×2. It is the storage primitive under the asynchronous FIFO and other buffers. Both ports share one clock here, and read data is registered.

---
 rtl/sb_ram_pkg.sv | 38 +++
 rtl/sb_ram_lane_map.sv | 35 +++
 rtl/sb_ram40_4k.sv | 81 ++++++++
 tb/tb_sb_ram40_4k.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sb_ram_pkg.sv
// Shared constants, port-geometry encoding and bit-position helpers for sb_ram40_4k.
package sb_ram_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int ROWS   = 256;
    localparam int ROW_W  = 8;
    localparam int LANE_W = ADDR_W - ROW_W;

    typedef enum logic [1:0] {
        MODE_16 = 2'd0,
        MODE_8  = 2'd1,
        MODE_4  = 2'd2,
        MODE_2  = 2'd3
    } ram_mode_e;

    // Position of logical bit i on the WDATA/RDATA pins.
    function automatic logic [3:0] port_pos(input ram_mode_e mode, input logic [3:0] i);
        case (mode)
            MODE_16: port_pos = i;
            MODE_8:  port_pos = {i[2:0], 1'b0};
            MODE_4:  port_pos = {i[1:0], 2'b01};
            default: port_pos = {i[0], 3'b011};
        endcase
    endfunction

    // Physical column of logical bit i: lanes interleave between the data bits.
    function automatic logic [3:0] phys_col(input ram_mode_e mode, input logic [3:0] i,
                                            input logic [LANE_W-1:0] lane);
        case (mode)
            MODE_16: phys_col = i;
            MODE_8:  phys_col = {i[2:0], lane[0]};
            MODE_4:  phys_col = {i[1:0], lane[1:0]};
            default: phys_col = {i[0], lane[2:0]};
        endcase
    endfunction

endpackage

// File: rtl/sb_ram_lane_map.sv
// Combinational port<->physical-column mapper for one RAM port geometry.
module sb_ram_lane_map
    import sb_ram_pkg::*;
#(
    parameter ram_mode_e MODE = MODE_16
) (
    input  logic [LANE_W-1:0] lane_sel,
    input  logic [DATA_W-1:0] port_wdata,
    input  logic [DATA_W-1:0] port_mask,
    output logic [DATA_W-1:0] col_en,
    output logic [DATA_W-1:0] col_wdata,
    input  logic [DATA_W-1:0] row_rdata,
    output logic [DATA_W-1:0] port_rdata
);

    localparam int unsigned     NBITS     = DATA_W >> MODE;
    localparam logic [LANE_W-1:0] LANE_MASK = LANE_W'((1 << MODE) - 1);

    logic [LANE_W-1:0] lane;

    assign lane = lane_sel & LANE_MASK;

    always_comb begin
        col_en     = '0;
        col_wdata  = '0;
        port_rdata = '0;
        for (int unsigned i = 0; i < NBITS; i++) begin
            // The bit mask only exists in the full-width geometry.
            col_en[phys_col(MODE, 4'(i), lane)]    = (MODE != MODE_16) || !port_mask[4'(i)];
            col_wdata[phys_col(MODE, 4'(i), lane)] = port_wdata[port_pos(MODE, 4'(i))];
            port_rdata[port_pos(MODE, 4'(i))]      = row_rdata[phys_col(MODE, 4'(i), lane)];
        end
    end

endmodule

// File: rtl/sb_ram40_4k.sv
// 4 Kbit single-clock block RAM, 256x16 physical, configurable port geometries.
// Define SB_RAM_INIT_ZERO_EN to start with an all-zero array.
module sb_ram40_4k
    import sb_ram_pkg::*;
#(
    parameter int READ_MODE  = 0,
    parameter int WRITE_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              WCLKE,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [DATA_W-1:0] MASK,
    input  logic              RCLKE,
    input  logic              RE,
    input  logic [ADDR_W-1:0] RADDR,
    output logic [DATA_W-1:0] RDATA
);

    localparam ram_mode_e RMODE = ram_mode_e'(READ_MODE[1:0]);
    localparam ram_mode_e WMODE = ram_mode_e'(WRITE_MODE[1:0]);

`ifdef SB_RAM_INIT_ZERO_EN
    logic [DATA_W-1:0] mem [ROWS] = '{default: '0};
`else
    logic [DATA_W-1:0] mem [ROWS];
`endif

    logic [DATA_W-1:0] wr_col_en;
    logic [DATA_W-1:0] wr_col_data;
    logic [DATA_W-1:0] wr_port_rdata_unused;
    logic [DATA_W-1:0] rd_row;
    logic [DATA_W-1:0] rd_port;
    logic [DATA_W-1:0] rd_col_en_unused;
    logic [DATA_W-1:0] rd_col_wdata_unused;

    sb_ram_lane_map #(
        .MODE(WMODE)
    ) u_wr_map (
        .lane_sel   (WADDR[ADDR_W-1:ROW_W]),
        .port_wdata (WDATA),
        .port_mask  (MASK),
        .col_en     (wr_col_en),
        .col_wdata  (wr_col_data),
        .row_rdata  ('0),
        .port_rdata (wr_port_rdata_unused)
    );

    assign rd_row = mem[RADDR[ROW_W-1:0]];

    sb_ram_lane_map #(
        .MODE(RMODE)
    ) u_rd_map (
        .lane_sel   (RADDR[ADDR_W-1:ROW_W]),
        .port_wdata ('0),
        .port_mask  ('0),
        .col_en     (rd_col_en_unused),
        .col_wdata  (rd_col_wdata_unused),
        .row_rdata  (rd_row),
        .port_rdata (rd_port)
    );

    // Array is not reset; writes are merely suppressed while rst_ is low.
    always_ff @(posedge clk) begin
        if (rst_ && WCLKE && WE) begin
            mem[WADDR[ROW_W-1:0]] <= (mem[WADDR[ROW_W-1:0]] & ~wr_col_en) |
                                     (wr_col_data & wr_col_en);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            RDATA <= '0;
        end else if (RCLKE && RE) begin
            RDATA <= rd_port;
        end
    end

endmodule

// File: tb/tb_sb_ram40_4k.sv
// Self-checking bench: five sb_ram40_4k geometries sharing one stimulus stream.
module tb_sb_ram40_4k;

    localparam int NI = 5;
    localparam int WM [NI] = '{0, 1, 2, 3, 1};
    localparam int RM [NI] = '{0, 1, 2, 3, 0};

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        wclke, we, rclke, re;
    logic [10:0] waddr, raddr;
    logic [15:0] wdata, mask;
    logic [15:0] rd [NI];

    logic [15:0] phys  [NI][256];
    logic [15:0] known [NI][256];
    logic [15:0] exp_rd [NI];
    logic [15:0] exp_km [NI];

    int npass = 0;
    int ntotal = 0;

    typedef struct {
        string       name;
        logic        wclke;
        logic        we;
        logic [10:0] waddr;
        logic [15:0] wdata;
        logic [15:0] mask;
        logic        rclke;
        logic        re;
        logic [10:0] raddr;
        logic [15:0] exp0;
    } vec_t;

    vec_t tv [12];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sb_ram40_4k #(
            .READ_MODE (RM[g]),
            .WRITE_MODE(WM[g])
        ) u_dut (
            .clk  (clk),
            .rst_ (rst_),
            .WCLKE(wclke),
            .WE   (we),
            .WADDR(waddr),
            .WDATA(wdata),
            .MASK (mask),
            .RCLKE(rclke),
            .RE   (re),
            .RADDR(raddr),
            .RDATA(rd[g])
        );
    end

    function automatic int ppos(int m, int i);
        case (m)
            0:       return i;
            1:       return 2 * i;
            2:       return 4 * i + 1;
            default: return 8 * i + 3;
        endcase
    endfunction

    task automatic model_write(int k);
        int m, row, ln, c;
        m   = WM[k];
        row = int'(waddr) % 256;
        ln  = (int'(waddr) / 256) % (1 << m);
        for (int i = 0; i < (16 >> m); i++) begin
            if (m != 0 || !mask[i]) begin
                c = i * (1 << m) + ln;
                phys[k][row][c]  = wdata[ppos(m, i)];
                known[k][row][c] = 1'b1;
            end
        end
    endtask

    task automatic model_read(int k);
        int m, row, ln, c;
        m   = RM[k];
        row = int'(raddr) % 256;
        ln  = (int'(raddr) / 256) % (1 << m);
        exp_rd[k] = '0;
        exp_km[k] = '1;
        for (int i = 0; i < (16 >> m); i++) begin
            c = i * (1 << m) + ln;
            exp_rd[k][ppos(m, i)] = phys[k][row][c];
            exp_km[k][ppos(m, i)] = known[k][row][c];
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            exp_rd[k] = '0;
            exp_km[k] = '1;
        end
    endtask

    task automatic tick();
        if (rst_ && rclke && re)
            for (int k = 0; k < NI; k++) model_read(k);
        if (rst_ && wclke && we)
            for (int k = 0; k < NI; k++) model_write(k);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(string nm);
        for (int k = 0; k < NI; k++) begin
            ntotal++;
            if ((rd[k] & exp_km[k]) !== (exp_rd[k] & exp_km[k]))
                $display("FAIL %s dut%0d RDATA=%h expected %h (compared bits %h)",
                         nm, k, rd[k], exp_rd[k], exp_km[k]);
            else
                npass++;
        end
    endtask

    task automatic check_val(string nm, logic [15:0] act, logic [15:0] exp);
        ntotal++;
        if (act !== exp)
            $display("FAIL %s RDATA=%h expected %h", nm, act, exp);
        else
            npass++;
    endtask

    task automatic set_in(logic wc, logic w, logic [10:0] wa, logic [15:0] wd,
                          logic [15:0] mk, logic rc, logic r, logic [10:0] ra);
        wclke = wc; we = w; waddr = wa; wdata = wd; mask = mk;
        rclke = rc; re = r; raddr = ra;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{"wr5_nore",  1, 1, 11'd5, 16'hA5C3, 16'h0000, 1, 0, 11'd0, 16'h0000};
        tv[1]  = '{"rd5",       0, 0, 11'd0, 16'h0000, 16'h0000, 1, 1, 11'd5, 16'hA5C3};
        tv[2]  = '{"hold_wr6",  1, 1, 11'd6, 16'h1234, 16'h0000, 1, 0, 11'd5, 16'hA5C3};
        tv[3]  = '{"wr7_ffff",  1, 1, 11'd7, 16'hFFFF, 16'h0000, 0, 0, 11'd0, 16'hA5C3};
        tv[4]  = '{"wr7_mask",  1, 1, 11'd7, 16'h0000, 16'h00FF, 1, 0, 11'd0, 16'hA5C3};
        tv[5]  = '{"rd7_mask",  0, 0, 11'd0, 16'h0000, 16'h0000, 1, 1, 11'd7, 16'h00FF};
        tv[6]  = '{"rd6",       0, 0, 11'd0, 16'h0000, 16'h0000, 1, 1, 11'd6, 16'h1234};
        tv[7]  = '{"rbw5_old",  1, 1, 11'd5, 16'h5A5A, 16'h0000, 1, 1, 11'd5, 16'hA5C3};
        tv[8]  = '{"rd5_new",   0, 0, 11'd0, 16'h0000, 16'h0000, 1, 1, 11'd5, 16'h5A5A};
        tv[9]  = '{"rclke_off", 0, 0, 11'd0, 16'h0000, 16'h0000, 0, 1, 11'd6, 16'h5A5A};
        tv[10] = '{"wclke_off", 0, 1, 11'd5, 16'h0000, 16'h0000, 1, 1, 11'd6, 16'h1234};
        tv[11] = '{"rd5_kept",  0, 0, 11'd0, 16'h0000, 16'h0000, 1, 1, 11'd5, 16'h5A5A};

        for (int k = 0; k < NI; k++)
            for (int r = 0; r < 256; r++) begin
                phys[k][r]  = '0;
                known[k][r] = '0;
            end
        set_in(0, 0, '0, '0, '0, 0, 0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_ = 1'b1;

        for (int v = 0; v < 12; v++) begin
            set_in(tv[v].wclke, tv[v].we, tv[v].waddr, tv[v].wdata, tv[v].mask,
                   tv[v].rclke, tv[v].re, tv[v].raddr);
            tick();
            check_val(tv[v].name, rd[0], tv[v].exp0);
            check_all(tv[v].name);
        end

        // Byte lanes 0/1 of row 0: 8'h12 and 8'h34 spread onto even pins.
        set_in(1, 1, 11'd0, 16'h0104, 16'h0000, 1, 0, 11'd0);
        tick();
        set_in(1, 1, 11'd256, 16'h0510, 16'h0000, 1, 0, 11'd0);
        tick();
        set_in(1, 0, 11'd0, 16'h0000, 16'h0000, 1, 1, 11'd0);
        tick();
        check_val("m8_rd0", rd[1], 16'h0104);
        check_val("mix_rd0", rd[4], 16'h0B24);
        check_all("m8_rd0");
        set_in(1, 0, 11'd0, 16'h0000, 16'h0000, 1, 1, 11'd256);
        tick();
        check_val("m8_rd256", rd[1], 16'h0510);
        check_val("mix_rd256", rd[4], 16'h0B24);
        check_all("m8_rd256");

        for (int a = 0; a < 2048; a++) begin
            set_in(1, 1, 11'(a), 16'($urandom), 16'h0000, 1, 0, 11'd0);
            tick();
        end
        for (int a = 0; a < 2048; a++) begin
            set_in(1, 0, 11'd0, 16'h0000, 16'h0000, 1, 1, 11'(a));
            tick();
            check_all("sweep_rd");
        end

        for (int n = 0; n < 1500; n++) begin
            set_in($urandom_range(0, 3) != 0, 1'($urandom), 11'($urandom), 16'($urandom),
                   ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000,
                   $urandom_range(0, 3) != 0, 1'($urandom), 11'($urandom));
            if ($urandom_range(0, 3) == 0) raddr = waddr;
            tick();
            check_all("rand");
        end

        set_in(1, 1, 11'd5, 16'hC33C, 16'h0000, 1, 1, 11'd7);
        tick();
        #2;
        rst_ = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        set_in(1, 1, 11'd5, 16'hFFFF, 16'h0000, 1, 1, 11'd5);
        tick();
        check_all("rst_held");
        #2;
        rst_ = 1'b1;
        set_in(0, 0, 11'd0, 16'h0000, 16'h0000, 1, 0, 11'd5);
        tick();
        check_all("rst_release_hold");
        set_in(0, 0, 11'd0, 16'h0000, 16'h0000, 1, 1, 11'd5);
        tick();
        check_val("rst_keep5", rd[0], 16'hC33C);
        check_all("rst_keep5");

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
